// File: rtl/uart_frame_packer_if.sv
// Byte-stream handshake between the frame packer and the UART transmitter.
// The master drives tx_valid/tx_data; the slave drives tx_ready.
interface uart_frame_packer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_frame_packer.sv
// UART transmit framer: snapshots a payload on start and streams
// SYNC0 SYNC1 DEV_ID LEN [SEQ] payload CRC8 TAIL over a valid/ready handshake.
module uart_frame_packer #(
  parameter int unsigned PAYLOAD_LEN = 26,
  parameter logic [7:0]  SYNC0       = 8'h55,
  parameter logic [7:0]  SYNC1       = 8'hBB,
  parameter logic [7:0]  DEV_ID      = 8'h01,
  parameter logic [7:0]  TAIL        = 8'hF0,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter logic [7:0]  CRC_INIT    = 8'h00,
  parameter bit          SEQ_EN      = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [8*PAYLOAD_LEN-1:0]   payload_data_i,
  uart_frame_packer_if.master        tx_if,
  output logic                       busy_o,
  output logic                       frame_done_o
);

  typedef enum logic [2:0] {StIdle, StHdr, StSeq, StPay, StCrc, StTail} state_e;

  localparam logic [7:0] LenByte = 8'(PAYLOAD_LEN);
  localparam logic [7:0] LastIdx = 8'(PAYLOAD_LEN - 1);

  state_e                     state_q;
  logic [7:0]                 idx_q;
  logic [8*PAYLOAD_LEN-1:0]   snap_q;
  logic [7:0]                 crc_q;
  logic [7:0]                 seq_q;
  logic                       tx_valid_q;
  logic [7:0]                 tx_data_q;
  logic                       busy_q;
  logic                       frame_done_q;

  logic       xfer;
  logic [7:0] idx_inc;
  logic [7:0] crc_upd;
  logic [7:0] hdr_nxt;
  logic [7:0] pay_nxt;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // tx_data_q always holds the byte on offer, so it is also the CRC input on transfer.
  always_comb begin
    xfer    = tx_valid_q & tx_if.tx_ready;
    idx_inc = idx_q + 8'd1;
    crc_upd = crc8_step(crc_q, tx_data_q);
    pay_nxt = snap_q[{idx_inc, 3'b000} +: 8];
    case (idx_inc[1:0])
      2'd1:    hdr_nxt = SYNC1;
      2'd2:    hdr_nxt = DEV_ID;
      default: hdr_nxt = LenByte;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      idx_q        <= 8'd0;
      snap_q       <= '0;
      crc_q        <= CRC_INIT;
      seq_q        <= 8'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            snap_q     <= payload_data_i;
            crc_q      <= CRC_INIT;
            idx_q      <= 8'd0;
            state_q    <= StHdr;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC0;
          end
        end
        StHdr: begin
          if (xfer) begin
            // SYNC0/SYNC1 (index 0,1) stay out of the CRC.
            if (idx_q >= 8'd2) crc_q <= crc_upd;
            if (idx_q == 8'd3) begin
              idx_q <= 8'd0;
              if (SEQ_EN) begin
                state_q   <= StSeq;
                tx_data_q <= seq_q;
              end else begin
                state_q   <= StPay;
                tx_data_q <= snap_q[7:0];
              end
            end else begin
              idx_q     <= idx_inc;
              tx_data_q <= hdr_nxt;
            end
          end
        end
        StSeq: begin
          if (xfer) begin
            crc_q     <= crc_upd;
            state_q   <= StPay;
            tx_data_q <= snap_q[7:0];
          end
        end
        StPay: begin
          if (xfer) begin
            crc_q <= crc_upd;
            if (idx_q == LastIdx) begin
              state_q   <= StCrc;
              tx_data_q <= crc_upd;
            end else begin
              idx_q     <= idx_inc;
              tx_data_q <= pay_nxt;
            end
          end
        end
        StCrc: begin
          if (xfer) begin
            state_q   <= StTail;
            tx_data_q <= TAIL;
          end
        end
        StTail: begin
          if (xfer) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b1;
            seq_q        <= seq_q + 8'd1;
          end
        end
        default: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
        end
      endcase
    end
  end

  assign tx_if.tx_valid = tx_valid_q;
  assign tx_if.tx_data  = tx_data_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer: three instances (defaults, short payload,
// sequence byte enabled) checked against a long-division CRC frame model.
module tb_uart_frame_packer;

  localparam int         PLEN [3] = '{26, 9, 26};
  localparam logic [7:0] DEV  [3] = '{8'h01, 8'h31, 8'h01};
  localparam bit         SEQE [3] = '{1'b0, 1'b0, 1'b1};

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic            st   [3];
  bit              rdy  [3];
  bit              rnd  [3];
  logic            vld  [3];
  logic [7:0]      dat  [3];
  logic            busy [3];
  logic            fd   [3];
  logic [7:0]      seq_m[3];
  logic [8:0]      exp_q[3][$];

  logic [8*26-1:0] pl0;
  logic [8*9-1:0]  pl1;
  logic [8*26-1:0] pl2;

  uart_frame_packer_if if0 ();
  uart_frame_packer_if if1 ();
  uart_frame_packer_if if2 ();

  assign if0.tx_ready = rdy[0];
  assign if1.tx_ready = rdy[1];
  assign if2.tx_ready = rdy[2];
  assign vld[0] = if0.tx_valid;
  assign vld[1] = if1.tx_valid;
  assign vld[2] = if2.tx_valid;
  assign dat[0] = if0.tx_data;
  assign dat[1] = if1.tx_data;
  assign dat[2] = if2.tx_data;

  uart_frame_packer u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .payload_data_i(pl0),
    .tx_if(if0), .busy_o(busy[0]), .frame_done_o(fd[0])
  );

  uart_frame_packer #(.PAYLOAD_LEN(9), .DEV_ID(8'h31)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .payload_data_i(pl1),
    .tx_if(if1), .busy_o(busy[1]), .frame_done_o(fd[1])
  );

  uart_frame_packer #(.SEQ_EN(1'b1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]), .payload_data_i(pl2),
    .tx_if(if2), .busy_o(busy[2]), .frame_done_o(fd[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Ready is updated just after each rising edge, so it is stable before the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rdy[d] = rnd[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h @%0t", name, d, act, want, $time);
    end
  endtask

  // CRC8 as the remainder of msg(x)*x^8 divided by x^8+x^2+x+1 (zero initial value).
  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    bit         bits[$];
    logic [8:0] gen = 9'h107;
    logic [7:0] r;
    foreach (msg[i]) for (int j = 7; j >= 0; j--) bits.push_back(msg[i][j]);
    repeat (8) bits.push_back(1'b0);
    for (int i = 0; i + 8 < bits.size(); i++)
      if (bits[i]) for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ gen[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = bits[bits.size()-8+j];
    return r;
  endfunction

  task automatic push_exp(input int d);
    logic [7:0] cov[$];
    logic [7:0] c;
    cov.push_back(DEV[d]);
    cov.push_back(8'(PLEN[d]));
    if (SEQE[d]) cov.push_back(seq_m[d]);
    for (int k = 0; k < PLEN[d]; k++) begin
      case (d)
        0:       cov.push_back(pl0[8*k +: 8]);
        1:       cov.push_back(pl1[8*k +: 8]);
        default: cov.push_back(pl2[8*k +: 8]);
      endcase
    end
    c = ref_crc(cov);
    exp_q[d].push_back({1'b0, 8'h55});
    exp_q[d].push_back({1'b0, 8'hBB});
    foreach (cov[i]) exp_q[d].push_back({1'b0, cov[i]});
    exp_q[d].push_back({1'b0, c});
    exp_q[d].push_back({1'b1, 8'hF0});
    seq_m[d] = seq_m[d] + 8'd1;
  endtask

  task automatic fire(input int d);
    @(posedge clk);
    #1;
    push_exp(d);
    st[d] = 1'b1;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((exp_q[d].size() != 0 || busy[d]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", d, {busy[d], 31'(exp_q[d].size())}, 0);
  endtask

  task automatic rand_pl(input int d);
    for (int k = 0; k < PLEN[d]; k++) begin
      case (d)
        0:       pl0[8*k +: 8] = 8'($urandom);
        1:       pl1[8*k +: 8] = 8'($urandom);
        default: pl2[8*k +: 8] = 8'($urandom);
      endcase
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stalls and frame_done.
  bit         stall[3];
  logic [7:0] pdat [3];
  bit         efd  [3];
  always @(negedge clk) begin
    logic [8:0] e;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        stall[d] = 1'b0;
        efd[d]   = 1'b0;
      end else begin
        if (efd[d] || fd[d]) chk("frame_done", d, fd[d], efd[d]);
        if (fd[d]) chk("idle_at_done", d, {vld[d], busy[d]}, 0);
        efd[d] = 1'b0;
        if (stall[d]) chk("stall_hold", d, {vld[d], dat[d]}, {1'b1, pdat[d]});
        if (!vld[d]) chk("data_idle", d, dat[d], 0);
        if (vld[d] && rdy[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected_byte", d, {1'b1, dat[d]}, 0);
          end else begin
            e = exp_q[d].pop_front();
            chk("byte", d, dat[d], e[7:0]);
            efd[d] = e[8];
          end
        end
        stall[d] = vld[d] && !rdy[d];
        pdat[d]  = dat[d];
      end
    end
  end

  initial begin
    logic [7:0] vec[$];
    int n;
    int last;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st[d]    = 1'b0;
      rnd[d]   = 1'b0;
      seq_m[d] = 8'd0;
    end
    for (int k = 0; k < 26; k++) pl0[8*k +: 8] = 8'(k);
    for (int k = 0; k < 9; k++)  pl1[8*k +: 8] = 8'(8'h31 + k);
    rand_pl(2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_state", d, {vld[d], dat[d], busy[d], fd[d]}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check_vector", 0, ref_crc(vec), 8'hF4);

    // Default frame, ready high: SYNC0 one cycle after accept, frame_done at t+33.
    fire(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("first_byte", 0, {vld[0], busy[0], dat[0]}, {2'b11, 8'h55});
    end while (!fd[0] && n < 100);
    chk("done_latency", 0, n, 33);
    wait_idle(0);

    fire(1);
    wait_idle(1);

    // Random back-pressure, starting with the incrementing payload.
    rnd[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) rand_pl(0);
      fire(0);
      wait_idle(0);
    end

    // Mid-frame start pulse and payload change must not disturb the frame.
    fire(0);
    repeat (10) @(negedge clk);
    chk("busy_mid", 0, busy[0], 1);
    @(posedge clk);
    #1 st[0] = 1'b1;
    rand_pl(0);
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_start", 0, busy[0], 1);
    wait_idle(0);
    repeat (40) @(negedge clk);
    chk("no_extra_frame", 0, vld[0], 0);
    rnd[0] = 1'b0;

    // Reset during payload on the sequence-enabled instance.
    fire(2);
    wait_idle(2);
    fire(2);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 2, {vld[2], busy[2], dat[2]}, 0);
    exp_q[2].delete();
    seq_m[2] = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 258 back-to-back frames, start raised in each frame_done cycle.
    rand_pl(2);
    fire(2);
    last = 0;
    for (int f = 1; f <= 258; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fd[2] && n < 100);
      chk("b2b_done", 2, fd[2], 1);
      if (f > 1) chk("period", 2, cyc - last, 34);
      last = cyc;
      if (f < 258) begin
        rand_pl(2);
        push_exp(2);
        st[2] = 1'b1;
        @(posedge clk);
        #1 st[2] = 1'b0;
      end
    end

    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) chk("queue_empty", d, exp_q[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
